// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte-wide transmit FIFO feeding a configurable UART serialiser.
// Frame format (5..8 data bits, none/even/odd parity, 1 or 2 stop bits) is
// captured when a byte is popped, so mid-frame config changes take effect on
// the next frame only.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [1:0]                    cfg_data_bits,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_stop2,
  output logic                          tx,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int AW           = $clog2(FIFO_DEPTH);
  localparam int BW           = $clog2(2 * CLKS_PER_BIT);

  // Terminal counts: one bit period, or the double-length stop period.
  localparam logic [BW-1:0] BIT_LAST   = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] STOP2_LAST = BW'(2 * CLKS_PER_BIT - 1);
  localparam logic [AW:0]   COUNT_FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // ---------------------------------------------------------------- FIFO
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push;
  logic          pop;
  logic [7:0]    head;

  assign in_ready   = (count_q != COUNT_FULL);
  assign push       = in_valid && in_ready;
  assign head       = mem[rd_ptr_q];
  assign fifo_count = count_q;

  // Storage write; held off during reset so reset-time enqueues leave no trace.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem[wr_ptr_q] <= in_data;
    end
  end

  // Pointer and occupancy next-state; simultaneous push and pop cancel in the count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO bookkeeping registers; reset empties the queue.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // ---------------------------------------------------------- serialiser
  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;          // index of the data bit on the line
  logic [2:0]    bit_last_q, bit_last_d; // data bits minus one (4..7)
  logic [7:0]    shreg_q, shreg_d;
  logic          par_en_q, par_en_d;
  logic          par_bit_q, par_bit_d;
  logic          stop2_q, stop2_d;
  logic          tx_q, tx_d;
  logic          bit_end;
  logic          load;
  logic [7:0]    data_mask;

  assign bit_end   = (baud_q == ((state_q == STOP && stop2_q) ? STOP2_LAST : BIT_LAST));
  assign data_mask = 8'hFF >> (2'd3 - cfg_data_bits);
  assign tx        = tx_q;
  assign busy      = (state_q != IDLE);
  assign tx_done   = (state_q == STOP) && bit_end;

  // Next-state and datapath control; 'load' starts a frame from the FIFO head.
  always_comb begin
    state_d    = state_q;
    baud_d     = bit_end ? '0 : baud_q + BW'(1);
    bit_d      = bit_q;
    bit_last_d = bit_last_q;
    shreg_d    = shreg_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    stop2_d    = stop2_q;
    tx_d       = tx_q;
    load       = 1'b0;
    pop        = 1'b0;

    case (state_q)
      IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (count_q != '0) begin
          load = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
          tx_d    = shreg_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == bit_last_q) begin
            if (par_en_q) begin
              state_d = PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 3'd1;
            shreg_d = shreg_q >> 1;
            tx_d    = shreg_q[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (count_q != '0) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    if (load) begin
      pop        = 1'b1;
      state_d    = START;
      baud_d     = '0;
      tx_d       = 1'b0;
      shreg_d    = head;
      bit_d      = '0;
      bit_last_d = {1'b1, cfg_data_bits};
      par_en_d   = ^cfg_parity;
      par_bit_d  = (^(head & data_mask)) ^ (cfg_parity == 2'b10);
      stop2_d    = cfg_stop2;
    end
  end

  // Serialiser state register; reset aborts any frame and idles the line high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      bit_last_q <= 3'd7;
      shreg_q    <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      bit_last_q <= bit_last_d;
      shreg_q    <= shreg_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      stop2_q    <= stop2_d;
      tx_q       <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed/randomised bench; a line monitor captures each
// frame cycle-by-cycle and a bit-list reference model predicts the waveform.
module tb_uart_tx_fifo;

  localparam int CLK_FREQ = 1000000;
  localparam int BAUD     = 100000;
  localparam int DEPTH    = 16;
  localparam int CPB      = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] cfg_data_bits;
  logic [1:0] cfg_parity;
  logic       cfg_stop2;
  logic       tx;
  logic       busy;
  logic       tx_done;
  logic [4:0] fifo_count;

  uart_tx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .cfg_data_bits(cfg_data_bits), .cfg_parity(cfg_parity),
    .cfg_stop2(cfg_stop2), .tx(tx), .busy(busy), .tx_done(tx_done),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           len;
    logic [127:0] wave;
    int           gap;
  } frame_t;

  frame_t frames[$];
  int checks = 0;
  int errors = 0;
  int stray_done = 0;

  int           mon_in_frame = 0;
  int           mon_len = 0;
  int           mon_gap = 0;
  logic [127:0] mon_wave = '0;

  // Line monitor: records every frame from its first low cycle to its tx_done cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        mon_in_frame = 0;
        mon_gap      = 0;
      end else begin
        if (mon_in_frame == 0) begin
          if (tx_done === 1'b1) stray_done++;
          if (tx === 1'b0) begin
            mon_in_frame = 1;
            mon_len      = 0;
            mon_wave     = '0;
          end else begin
            mon_gap++;
          end
        end
        if (mon_in_frame != 0) begin
          if (mon_len < 128) mon_wave[mon_len] = tx;
          mon_len++;
          if (tx_done === 1'b1) begin
            frame_t fr;
            fr.len  = mon_len;
            fr.wave = mon_wave;
            fr.gap  = mon_gap;
            frames.push_back(fr);
            mon_in_frame = 0;
            mon_gap      = 0;
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic enqueue(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic set_cfg(input logic [1:0] db, input logic [1:0] par, input logic s2);
    cfg_data_bits = db;
    cfg_parity    = par;
    cfg_stop2     = s2;
  endtask

  // Reference model: list of line bits (start, N data LSB first, optional parity, stops).
  function automatic void build_frame(input logic [7:0] b, input logic [1:0] db,
                                      input logic [1:0] par, input logic s2,
                                      output int len, output logic [127:0] w);
    bit seq[$];
    bit p;
    int n;
    n = int'(db) + 5;
    p = 1'b0;
    seq.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      seq.push_back(b[i]);
      p ^= b[i];
    end
    if (par == 2'b01) seq.push_back(p);
    else if (par == 2'b10) seq.push_back(!p);
    seq.push_back(1'b1);
    if (s2) seq.push_back(1'b1);
    len = seq.size() * CPB;
    w   = '0;
    for (int k = 0; k < seq.size(); k++)
      for (int c = 0; c < CPB; c++)
        w[k*CPB + c] = seq[k];
  endfunction

  task automatic wait_frames(input int n, input int budget, input string tag);
    int cyc;
    cyc = 0;
    while (frames.size() < n && cyc < budget) begin
      step();
      cyc++;
    end
    chk({tag, "_frames"}, 128'(frames.size()), 128'(n));
  endtask

  task automatic check_frame(input int idx, input logic [7:0] b, input logic [1:0] db,
                             input logic [1:0] par, input logic s2,
                             input bit gap0, input string tag);
    int           elen;
    logic [127:0] ew;
    build_frame(b, db, par, s2, elen, ew);
    if (idx < frames.size()) begin
      $display("frame %s: byte=%02h cfg=%0d/%0d/%0d len=%0d", tag, b, db, par, s2, frames[idx].len);
      chk({tag, "_len"}, 128'(frames[idx].len), 128'(elen));
      chk({tag, "_wave"}, frames[idx].wave, ew);
      if (gap0) chk({tag, "_gap"}, 128'(frames[idx].gap), 128'd0);
    end
  endtask

  initial begin
    logic [7:0] burst[20];
    logic [7:0] exp_q[$];
    logic [7:0] rb;
    logic [7:0] rb2;
    logic [1:0] rdb;
    logic [1:0] rpar;
    logic       rs2;
    int         mcount;
    bit         acc;

    rst_n    = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    set_cfg(2'b11, 2'b00, 1'b0);

    // Reset state.
    repeat (3) step();
    chk("rst_tx", 128'(tx), 128'd1);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(tx_done), 128'd0);
    chk("rst_count", 128'(fifo_count), 128'd0);
    chk("rst_ready", 128'(in_ready), 128'd1);
    rst_n = 1'b1;
    repeat (3) step();

    // Single byte 8N1 0xA5 with first-frame latency.
    enqueue(8'hA5);
    chk("lat_tx_e", 128'(tx), 128'd1);
    chk("lat_busy_e", 128'(busy), 128'd0);
    chk("lat_count_e", 128'(fifo_count), 128'd1);
    step();
    chk("lat_tx_e1", 128'(tx), 128'd0);
    chk("lat_busy_e1", 128'(busy), 128'd1);
    chk("lat_count_e1", 128'(fifo_count), 128'd0);
    wait_frames(1, 300, "a5");
    check_frame(0, 8'hA5, 2'b11, 2'b00, 1'b0, 1'b0, "a5");
    step();
    chk("a5_idle_busy", 128'(busy), 128'd0);
    frames.delete();
    repeat (5) step();

    // 7E2 0x41.
    set_cfg(2'b10, 2'b01, 1'b1);
    enqueue(8'h41);
    wait_frames(1, 300, "7e2");
    check_frame(0, 8'h41, 2'b10, 2'b01, 1'b1, 1'b0, "7e2");
    frames.delete();
    repeat (5) step();

    // 5O1 0xFF.
    set_cfg(2'b00, 2'b10, 1'b0);
    enqueue(8'hFF);
    wait_frames(1, 300, "5o1");
    check_frame(0, 8'hFF, 2'b00, 2'b10, 1'b0, 1'b0, "5o1");
    frames.delete();
    repeat (5) step();

    // Random formats and bytes.
    for (int t = 0; t < 6; t++) begin
      rb   = 8'($urandom);
      rdb  = 2'($urandom);
      rpar = 2'($urandom);
      rs2  = 1'($urandom);
      set_cfg(rdb, rpar, rs2);
      enqueue(rb);
      wait_frames(1, 300, $sformatf("rnd%0d", t));
      check_frame(0, rb, rdb, rpar, rs2, 1'b0, $sformatf("rnd%0d", t));
      frames.delete();
      repeat (3) step();
    end

    // Burst of 20 back-to-back offers into an idle 16-deep FIFO.
    set_cfg(2'b11, 2'b00, 1'b0);
    for (int k = 0; k < 20; k++) burst[k] = 8'($urandom);
    mcount = 0;
    for (int k = 1; k <= 20; k++) begin
      chk($sformatf("burst_ready%0d", k), 128'(in_ready), 128'(mcount < DEPTH));
      chk($sformatf("burst_count%0d", k), 128'(fifo_count), 128'(mcount));
      acc      = (mcount < DEPTH);
      in_data  = burst[k-1];
      in_valid = 1'b1;
      step();
      $display("burst offer %0d: byte=%02h accepted=%0d", k, burst[k-1], acc);
      if (acc) begin
        exp_q.push_back(burst[k-1]);
        mcount++;
      end
      if (k == 2) mcount--;
    end
    in_valid = 1'b0;
    chk("burst_count_end", 128'(fifo_count), 128'(mcount));
    wait_frames(exp_q.size(), 17 * 110 + 200, "burst");
    for (int i = 0; i < exp_q.size(); i++)
      check_frame(i, exp_q[i], 2'b11, 2'b00, 1'b0, (i > 0), $sformatf("burst%0d", i));
    repeat (300) step();
    chk("burst_no_extra", 128'(frames.size()), 128'(exp_q.size()));
    frames.delete();
    repeat (5) step();

    // Reset mid-frame with bytes queued; enqueues during reset are ignored.
    enqueue(8'($urandom));
    enqueue(8'($urandom));
    enqueue(8'($urandom));
    repeat (30) step();
    chk("midrst_busy_before", 128'(busy), 128'd1);
    rst_n    = 1'b0;
    in_data  = 8'h5A;
    in_valid = 1'b1;
    step();
    chk("midrst_tx", 128'(tx), 128'd1);
    chk("midrst_busy", 128'(busy), 128'd0);
    chk("midrst_count", 128'(fifo_count), 128'd0);
    step();
    chk("midrst_count2", 128'(fifo_count), 128'd0);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    repeat (400) step();
    chk("midrst_no_frames", 128'(frames.size()), 128'd0);
    chk("midrst_tx_idle", 128'(tx), 128'd1);
    chk("midrst_busy_idle", 128'(busy), 128'd0);
    frames.delete();

    // Config change while the first frame is in DATA.
    set_cfg(2'b11, 2'b00, 1'b0);
    rb  = 8'($urandom);
    rb2 = 8'($urandom);
    enqueue(rb);
    enqueue(rb2);
    repeat (30) step();
    set_cfg(2'b10, 2'b01, 1'b1);
    wait_frames(2, 400, "cfgchg");
    check_frame(0, rb, 2'b11, 2'b00, 1'b0, 1'b0, "cfgchg0");
    check_frame(1, rb2, 2'b10, 2'b01, 1'b1, 1'b1, "cfgchg1");
    repeat (20) step();

    chk("stray_tx_done", 128'(stray_done), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 100000000, system clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 115200, line rate in bit/s; CLKS_PER_BIT = CLK_FREQ/BAUD, integer-truncated (868 at defaults), and SHALL be at least 2.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 16, transmit FIFO entries; it SHALL be a power of 2 and at least 2.
REQ-004 The block SHALL have port clk, input, 1 bit, the single system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit, reset that is synchronous and active-low.
REQ-006 The block SHALL have port in_data, input, 8 bits, byte to enqueue.
REQ-007 The block SHALL have port in_valid, input, 1 bit, enqueue request.
REQ-008 The block SHALL have port in_ready, output, 1 bit, FIFO can accept; it SHALL equal !full, combinationally.
REQ-009 The block SHALL have port cfg_data_bits, input, 2 bits, frame length: 00=5, 01=6, 10=7, 11=8 data bits.
REQ-010 The block SHALL have port cfg_parity, input, 2 bits: 00=none, 01=even, 10=odd, 11=none.
REQ-011 The block SHALL have port cfg_stop2, input, 1 bit: 0=one stop bit, 1=two stop bits.
REQ-012 The block SHALL have port tx, output, 1 bit, serial line, registered, idle high.
REQ-013 The block SHALL have port busy, output, 1 bit, high whenever the FSM is not in IDLE.
REQ-014 The block SHALL have port tx_done, output, 1 bit, one-cycle pulse at the end of each frame.
REQ-015 The block SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1 bits, current FIFO occupancy.

Function
REQ-016 An enqueue SHALL occur on any rising edge where in_valid and in_ready are both 1; data offered while in_ready=0 SHALL be dropped and SHALL NOT change FIFO state.
REQ-017 The FIFO SHALL be first-in first-out with wrapping read and write pointers; fifo_count SHALL range 0..FIFO_DEPTH, and full SHALL mean fifo_count==FIFO_DEPTH.
REQ-018 On an edge with both an enqueue and a pop, fifo_count SHALL be unchanged, with both operations taking effect.
REQ-019 The FSM SHALL use states IDLE, START, DATA, PARITY and STOP.
REQ-020 In IDLE with fifo_count>0, the block SHALL pop the head byte on the next edge, latch that byte and cfg_data_bits, cfg_parity and cfg_stop2, drive tx=0 and enter START.
REQ-021 Configuration changes during a frame SHALL NOT affect that frame.
REQ-022 A byte enqueued into an empty FIFO at edge E SHALL drive tx low after edge E+1; that is, the pop occurs no earlier than the edge after the enqueue.
REQ-023 Each START, DATA and PARITY bit SHALL hold tx for exactly CLKS_PER_BIT cycles.
REQ-024 STOP SHALL hold tx=1 for CLKS_PER_BIT cycles, or 2*CLKS_PER_BIT cycles when the latched stop2=1.
REQ-025 DATA SHALL send latched bits [0..N-1] LSB first, where N is the latched data-bit count; byte bits at index N and above SHALL be ignored.
REQ-026 The PARITY state SHALL be entered only when the latched parity mode is 01 or 10; otherwise DATA SHALL go directly to STOP.
REQ-027 The parity bit SHALL be the XOR of the N sent bits for even parity, and its inverse for odd parity.
REQ-028 At the last cycle of STOP, tx_done SHALL pulse high for 1 cycle.
REQ-029 At that same edge, if fifo_count>0 the block SHALL pop and go to START with no idle cycle between frames; otherwise it SHALL go to IDLE.
REQ-030 The bit counter and baud counter SHALL NOT wrap or overflow for any legal parameter set; the baud counter width SHALL be $clog2(2*CLKS_PER_BIT).

Reset
REQ-031 On any rising edge with rst_n=0, the block SHALL set tx=1, busy=0, tx_done=0 and fifo_count=0, set both FIFO pointers to 0, and put the FSM in IDLE.
REQ-032 Reset asserted mid-frame SHALL abort the frame, with tx high after that edge, and SHALL discard all queued bytes.
REQ-033 FIFO storage contents need no reset.
REQ-034 Enqueues SHALL be ignored while rst_n=0.

Verification
(All scenarios use CLK_FREQ=1000000 and BAUD=100000, so CLKS_PER_BIT=10.)
REQ-035 Single byte: 8-bit, no parity, 1 stop, in_data=0xA5 -> tx after the start bit reads 1,0,1,0,0,1,0,1, then 1; the frame lasts 100 cycles and tx_done pulses once.
REQ-036 7E2: cfg=10/01/1, byte 0x41 -> data bits 1,0,0,0,0,0,1, then parity 0, then 20 cycles of high; the frame lasts 110 cycles.
REQ-037 5O1: cfg=00/10/0, byte 0xFF -> 5 ones, then parity 0; bits 5-7 are never sent; the frame lasts 80 cycles.
REQ-038 Burst: enqueue 17 bytes back-to-back with FIFO_DEPTH=16 -> in_ready falls when the FIFO is full; all accepted bytes transmit in order with no idle cycle between stop and the next start; dropped bytes are absent.
REQ-039 Reset mid-frame: assert rst_n=0 during DATA with 3 bytes queued -> tx=1, busy=0 and fifo_count=0 after that edge, and no further frames transmit.
REQ-040 Config change mid-frame: switch from 8N1 to 7E2 while the first byte is in DATA -> the first frame completes as 8N1 and the second frame is 7E2.
